// File: rtl/add_serial_feeder.sv
// add_serial_feeder: operand sequencer in front of the serial adder.
// Queues (a,b) pairs in a small FIFO, launches one add at a time with a
// single-cycle add_en pulse, waits a fixed number of cycles for the adder's
// result and then offers it on a valid/ready result port.
module add_serial_feeder #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 4,
   parameter int ADD_CYCLES = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             add_en,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(ADD_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // in_ready depends on full only, so a full FIFO refuses even while popping.
   assign in_ready = !full;
   assign push     = in_valid && !full;

   // Pop whenever the FSM launches: from IDLE, or straight from HOLD on handshake.
   assign pop = !empty && ((state == IDLE) || (state == HOLD && res_ready));

   // Operand storage; the head becomes visible to the FSM one cycle after a push.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr[AW-1:0]] <= in_a;
         mem_b[wr_ptr[AW-1:0]] <= in_b;
      end
   end

   // FIFO pointers; a simultaneous push and pop leaves occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Launch / wait / hold sequencer with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         add_en    <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  add_a  <= mem_a[rd_ptr[AW-1:0]];
                  add_b  <= mem_b[rd_ptr[AW-1:0]];
                  add_en <= 1'b1;
                  state  <= LAUNCH;
               end
            end
            LAUNCH: begin
               add_en <= 1'b0;
               cnt    <= CW'(ADD_CYCLES - 1);
               state  <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  res_sum   <= add_out;
                  res_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (pop) begin
                     add_a  <= mem_a[rd_ptr[AW-1:0]];
                     add_b  <= mem_b[rd_ptr[AW-1:0]];
                     add_en <= 1'b1;
                     state  <= LAUNCH;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_serial_feeder.sv
// Directed testbench for add_serial_feeder with a behavioural serial-adder model.
module tb_add_serial_feeder;

   localparam int ADD_CYCLES = 10;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       add_en;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic [7:0] add_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_sum;

   int n_cmp  = 0;
   int n_fail = 0;
   int en_cnt = 0;

   add_serial_feeder #(.WIDTH(8), .DEPTH(4), .ADD_CYCLES(ADD_CYCLES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .add_en(add_en), .add_a(add_a), .add_b(add_b),
      .add_out(add_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Serial adder model: junk right after launch, true sum only ADD_CYCLES later.
   initial begin
      logic [7:0] s;
      add_out = 8'h00;
      forever begin
         @(negedge clk);
         if (add_en) begin
            en_cnt++;
            s = add_a + add_b;
            add_out = 8'hA5;
            repeat (ADD_CYCLES) @(posedge clk);
            #1 add_out = s;
         end
      end
   end

   task automatic push_pair(input logic [7:0] a, input logic [7:0] b, output bit ok);
      ok = 1'b0;
      in_valid = 1'b1; in_a = a; in_b = b;
      for (int k = 0; k < 60; k++) begin
         if (in_ready) begin
            @(negedge clk);
            in_valid = 1'b0;
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_res(output int cyc, output bit ok);
      ok = 1'b0; cyc = 0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (res_valid) begin cyc = k; ok = 1'b1; return; end
      end
   endtask

   task automatic consume();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if ({add_en, res_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {add_en, res_valid}); end
      n_cmp++; if ({add_a, add_b, res_sum} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", {add_a, add_b, res_sum}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int cyc; bit ok; int en0;
      en0 = en_cnt;
      in_valid = 1'b1; in_a = 8'h25; in_b = 8'h13;
      @(negedge clk);                        // pushed on the edge just passed
      in_valid = 1'b0;
      n_cmp++; if (add_en !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: add_en got %b want 0", add_en); end
      @(negedge clk);
      n_cmp++; if (add_en !== 1'b1) begin n_fail++; $display("FAIL single_launch: add_en got %b want 1", add_en); end
      n_cmp++; if ({add_a, add_b} !== 16'h2513) begin n_fail++; $display("FAIL single_operands: got %h want 2513", {add_a, add_b}); end
      @(negedge clk);
      n_cmp++; if (add_en !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: add_en got %b want 0", add_en); end
      wait_res(cyc, ok);
      // res_valid rises on the 12th edge after the push edge: 10 negedges from here
      n_cmp++; if (!ok || cyc != 10) begin n_fail++; $display("FAIL single_latency: got %0d want 10 (ok=%b)", cyc, ok); end
      n_cmp++; if (res_sum !== 8'h38) begin n_fail++; $display("FAIL single_sum: got %h want 38", res_sum); end
      n_cmp++; if (en_cnt - en0 != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d want 1", en_cnt - en0); end
      consume();
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_res_drop: got %b want 0", res_valid); end
   endtask

   task automatic test_wrap();
      int cyc; bit ok;
      push_pair(8'hFF, 8'h01, ok);
      wait_res(cyc, ok);
      n_cmp++; if (!ok || res_sum !== 8'h00) begin n_fail++; $display("FAIL wrap_ff_01: got %h want 00 (ok=%b)", res_sum, ok); end
      consume();
      push_pair(8'h80, 8'h80, ok);
      wait_res(cyc, ok);
      n_cmp++; if (!ok || res_sum !== 8'h00) begin n_fail++; $display("FAIL wrap_80_80: got %h want 00 (ok=%b)", res_sum, ok); end
      consume();
   endtask

   task automatic test_full();
      logic [7:0] ta [6];
      logic [7:0] tb [6];
      logic [7:0] te [6];
      int idx, rcnt, first_block, last_t, took;
      ta = '{8'h01, 8'h10, 8'h7F, 8'hF0, 8'h55, 8'hC8};
      tb = '{8'h02, 8'h20, 8'h01, 8'h20, 8'hAA, 8'h64};
      te = '{8'h03, 8'h30, 8'h80, 8'h10, 8'hFF, 8'h2C};
      res_ready = 1'b0;
      idx = 0; first_block = -1;
      in_valid = 1'b1; in_a = ta[0]; in_b = tb[0];
      for (int k = 0; k < 10; k++) begin
         took = int'(in_ready);
         if (!in_ready && first_block < 0) first_block = k;
         @(negedge clk);
         if (took != 0) begin
            idx++;
            if (idx < 6) begin in_a = ta[idx]; in_b = tb[idx]; end
            else in_valid = 1'b0;
         end
      end
      // one launched + DEPTH buffered; the sixth pair is held back by the source
      n_cmp++; if (idx != 5) begin n_fail++; $display("FAIL full_accepted: got %0d want 5", idx); end
      n_cmp++; if (first_block != 5) begin n_fail++; $display("FAIL full_in_ready_drop: got cycle %0d want 5", first_block); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      res_ready = 1'b1;
      rcnt = 0; last_t = 0;
      for (int k = 0; k < 200 && rcnt < 6; k++) begin
         took = int'(in_valid && in_ready);
         if (res_valid) begin
            n_cmp++; if (res_sum !== te[rcnt]) begin n_fail++; $display("FAIL full_order_%0d: got %h want %h", rcnt, res_sum, te[rcnt]); end
            if (rcnt >= 1) begin
               n_cmp++; if (k - last_t != ADD_CYCLES + 2) begin n_fail++; $display("FAIL full_throughput_%0d: got %0d want %0d", rcnt, k - last_t, ADD_CYCLES + 2); end
            end
            last_t = k;
            rcnt++;
         end
         @(negedge clk);
         if (took != 0) begin idx++; in_valid = 1'b0; end
      end
      res_ready = 1'b0;
      n_cmp++; if (rcnt != 6 || idx != 6) begin n_fail++; $display("FAIL full_drain: got %0d results %0d pushes want 6/6", rcnt, idx); end
   endtask

   task automatic test_backpressure();
      int cyc; bit ok; int en0; bit stable;
      res_ready = 1'b0;
      push_pair(8'h12, 8'h34, ok);
      push_pair(8'hAB, 8'hCD, ok);
      wait_res(cyc, ok);
      n_cmp++; if (!ok || res_sum !== 8'h46) begin n_fail++; $display("FAIL bp_first_sum: got %h want 46 (ok=%b)", res_sum, ok); end
      en0 = en_cnt; stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (res_sum !== 8'h46 || res_valid !== 1'b1 || add_en !== 1'b0) stable = 1'b0;
      end
      n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold_stable: got %b want 1", stable); end
      n_cmp++; if (en_cnt != en0) begin n_fail++; $display("FAIL bp_no_launch: got %0d pulses want 0", en_cnt - en0); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++; if ({add_en, res_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release_launch: got %b want 10", {add_en, res_valid}); end
      n_cmp++; if ({add_a, add_b} !== 16'hABCD) begin n_fail++; $display("FAIL bp_second_operands: got %h want abcd", {add_a, add_b}); end
      wait_res(cyc, ok);
      n_cmp++; if (!ok || res_sum !== 8'h78) begin n_fail++; $display("FAIL bp_second_sum: got %h want 78 (ok=%b)", res_sum, ok); end
      consume();
   endtask

   task automatic test_reset_mid();
      int cyc; bit ok; bit bad;
      res_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
      @(negedge clk);
      in_a = 8'h33; in_b = 8'h44;
      @(negedge clk);
      n_cmp++; if (add_en !== 1'b1) begin n_fail++; $display("FAIL rm_launch: add_en got %b want 1", add_en); end
      in_a = 8'h55; in_b = 8'h66;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);             // four cycles after the add_en cycle
      rst = 1'b1;
      #1;
      n_cmp++; if ({add_en, res_valid, in_ready} !== 3'b001) begin n_fail++; $display("FAIL rm_async_flags: got %b want 001", {add_en, res_valid, in_ready}); end
      n_cmp++; if ({add_a, add_b, res_sum} !== 24'h0) begin n_fail++; $display("FAIL rm_async_data: got %h want 000000", {add_a, add_b, res_sum}); end
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || add_en !== 1'b0) bad = 1'b1;
      end
      n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rm_flushed: activity got %b want 0", bad); end
      push_pair(8'h21, 8'h43, ok);
      wait_res(cyc, ok);
      n_cmp++; if (!ok || res_sum !== 8'h64) begin n_fail++; $display("FAIL rm_recover_sum: got %h want 64 (ok=%b)", res_sum, ok); end
      consume();
   endtask

   task automatic test_push_pop();
      logic [7:0] q [$];
      logic [7:0] a, b, want;
      int nxt, rcnt;
      res_ready = 1'b1;
      nxt = 0; rcnt = 0;
      for (int i = 0; i < 4; i++) begin
         a = 8'(i * 29 + 7); b = 8'(8'hE0 ^ i);
         n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pp_fill_ready_%0d: got %b want 1", i, in_ready); end
         in_valid = 1'b1; in_a = a; in_b = b; q.push_back(a + b);
         @(negedge clk);
         nxt++;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 400 && rcnt < 12; k++) begin
         if (res_valid) begin
            want = q.pop_front();
            n_cmp++; if (res_sum !== want) begin n_fail++; $display("FAIL pp_order_%0d: got %h want %h", rcnt, res_sum, want); end
            rcnt++;
            if (nxt < 12) begin
               // push coincides with the pop of this handshake at DEPTH-1 occupancy
               n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_%0d: got %b want 1", nxt, in_ready); end
               a = 8'(nxt * 29 + 7); b = 8'(8'hE0 ^ nxt);
               in_valid = 1'b1; in_a = a; in_b = b; q.push_back(a + b);
               nxt++;
            end
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
      res_ready = 1'b0;
      n_cmp++; if (rcnt != 12) begin n_fail++; $display("FAIL pp_count: got %0d want 12", rcnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_full();
      test_backpressure();
      test_reset_mid();
      test_push_pop();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
